gf256_inv_seq: RTL

Sequential GF(2^8) exponentiator/inverter for the SEED S-box datapath. Computes din^EXP over GF(2^8) modulo the SEED field polynomial by left-to-right square-and-multiply, using one shared GF(2^8) multiplier over several cycles. With the default EXP = 254 it returns the multiplicative inverse (din^-1, with 0 -> 0). EXP = 247 or 251 yields the SEED S1/S2 power terms for the serialized 8-bit round.

---
 rtl/gf256_inv_seq.sv | 118 +++++++++++
 1 files changed

// File: rtl/gf256_inv_seq.sv
// Sequential GF(2^8) exponentiator: din^EXP mod POLY by left-to-right square-and-multiply,
// sharing a single combinational GF(2^8) multiplier across the SQR and MUL states.
module gf256_inv_seq #(
   parameter logic [8:0] POLY = 9'h163,
   parameter logic [7:0] EXP  = 8'd254
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] din,
   output logic       busy,
   output logic       done,
   output logic [7:0] dout
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SQR  = 2'd1,
      S_MUL  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] a_q, a_d;
   logic [7:0] r_q, r_d;
   logic [2:0] i_q, i_d;
   logic [7:0] dout_q, dout_d;
   logic [7:0] mul_y;
   logic [7:0] mul_p;

   // Shift-and-add multiply; x is doubled each step and folded back by POLY on carry-out.
   function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
      logic [7:0] acc;
      logic [7:0] sh;
      acc = 8'h00;
      sh  = x;
      for (int b = 0; b < 8; b++) begin
         if (y[b]) acc = acc ^ sh;
         sh = sh[7] ? ({sh[6:0], 1'b0} ^ POLY[7:0]) : {sh[6:0], 1'b0};
      end
      return acc;
   endfunction

   always_comb begin
      mul_y = (state_q == S_MUL) ? a_q : r_q;
      mul_p = gf_mul(r_q, mul_y);
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_SQR;
         S_SQR: begin
            if (EXP[i_q])        state_d = S_MUL;
            else if (i_q == 3'd0) state_d = S_DONE;
         end
         S_MUL:   state_d = (i_q == 3'd0) ? S_DONE : S_SQR;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // The bit index only advances once both the square and any multiply for that bit are done.
   always_comb begin
      a_d    = a_q;
      r_d    = r_q;
      i_d    = i_q;
      dout_d = dout_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               a_d = din;
               r_d = 8'h01;
               i_d = 3'd7;
            end
         end
         S_SQR: begin
            r_d = mul_p;
            if (!EXP[i_q]) begin
               if (i_q == 3'd0) dout_d = mul_p;
               else             i_d    = i_q - 3'd1;
            end
         end
         S_MUL: begin
            r_d = mul_p;
            if (i_q == 3'd0) dout_d = mul_p;
            else             i_d    = i_q - 3'd1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q    <= 8'h00;
         r_q    <= 8'h00;
         i_q    <= 3'd0;
         dout_q <= 8'h00;
      end else begin
         a_q    <= a_d;
         r_q    <= r_d;
         i_q    <= i_d;
         dout_q <= dout_d;
      end
   end

   always_comb begin
      busy = (state_q == S_SQR) || (state_q == S_MUL);
      done = (state_q == S_DONE);
      dout = dout_q;
   end

endmodule
